uart_stream: RTL

Parametrised full-duplex UART with FIFO-buffered valid/ready streaming on both directions, runtime-independent frame format fixed at elaboration (data width, stop bits, optional parity). It is the successor to the single-byte UART used by the host link: instead of a fixed 4-byte TX burst and a pulse-only RX, it sits between the UART pins and any stream consumer or producer (command decoder, NPU result dumper) with back-pressure, error flags and overrun detection.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_stream.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for uart_stream: FSM encoding used by both TX and RX,
// parity mode constants, default divider and FIFO level width helper.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   localparam int unsigned ParityEven    = 0;
   localparam int unsigned ParityOdd     = 1;
   localparam int unsigned DefaultClkDiv = 434;

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [PtrW:0]     level_q;
   logic              do_push, do_pop;

   assign full_o  = (level_q == (PtrW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + PtrW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (PtrW+1)'(1);
            2'b01:   level_q <= level_q - (PtrW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_stream.sv
// Full-duplex UART with FIFO-buffered valid/ready streams on TX and RX.
// Define UART_PARITY_EN to add a parity bit (transmitted and checked).
module uart_stream
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DefaultClkDiv,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = ParityEven,
   parameter int unsigned TX_DEPTH   = 16,
   parameter int unsigned RX_DEPTH   = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               uart_rxd_i,
   output logic                               uart_txd_o,
   input  logic                               tx_valid_i,
   output logic                               tx_ready_o,
   input  logic [DATA_BITS-1:0]               tx_data_i,
   output logic                               tx_busy_o,
   output logic [level_width(TX_DEPTH)-1:0]   tx_level_o,
   output logic                               rx_valid_o,
   input  logic                               rx_ready_i,
   output logic [DATA_BITS-1:0]               rx_data_o,
   output logic                               rx_frame_err_o,
   output logic                               rx_parity_err_o,
   output logic                               rx_overrun_o,
   output logic [level_width(RX_DEPTH)-1:0]   rx_level_o
);

   localparam int unsigned     CntW     = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
   localparam logic [2:0]      DataLast = 3'(DATA_BITS - 1);
   localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
   localparam logic            OddBit   = 1'(PARITY_ODD);
   localparam int unsigned     EntryW   = DATA_BITS + 2;
`else
   localparam int unsigned     EntryW   = DATA_BITS + 1;
`endif

   if (CLK_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD > ParityOdd) begin : g_bad_cfg
      $error("uart_stream: illegal configuration");
   end

   // ---------------- TX ----------------
   uart_state_e          tx_state_q, tx_state_d;
   logic [CntW-1:0]      tx_div_q, tx_div_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, tx_rdata;
   logic                 txd_q, txd_d, tx_pop, tx_wrap, tx_full, tx_empty;
`ifdef UART_PARITY_EN
   logic                 tx_par_q, tx_par_d;
`endif

   assign tx_ready_o = !tx_full;
   assign tx_busy_o  = (tx_state_q != StIdle) || !tx_empty;
   assign uart_txd_o = txd_q;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (tx_valid_i && tx_ready_o),
      .wdata_i (tx_data_i),
      .pop_i   (tx_pop),
      .rdata_o (tx_rdata),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .level_o (tx_level_o)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      txd_d      = 1'b1;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      tx_wrap    = (tx_div_q == DivLast);
      if (tx_state_q != StIdle) tx_div_d = tx_wrap ? '0 : tx_div_q + CntW'(1);
      unique case (tx_state_q)
         StIdle:  tx_pop = !tx_empty;
         StStart: begin
            txd_d = 1'b0;
            if (tx_wrap) begin
               tx_state_d = StData;
               tx_bit_d   = '0;
            end
         end
         StData: begin
            txd_d = tx_shift_q[0];
            if (tx_wrap) begin
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == DataLast) begin
                  tx_bit_d = '0;
`ifdef UART_PARITY_EN
                  tx_state_d = StParity;
`else
                  tx_state_d = StStop;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         StParity: begin
            txd_d = tx_par_q;
            if (tx_wrap) tx_state_d = StStop;
         end
`endif
         StStop: begin
            if (tx_wrap) begin
               if (tx_bit_q == StopLast) begin
                  // Chain straight into the next start bit when data is waiting.
                  tx_pop     = !tx_empty;
                  tx_state_d = StIdle;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
         default: tx_state_d = StIdle;
      endcase
      if (tx_pop) begin
         tx_state_d = StStart;
         tx_div_d   = '0;
         tx_bit_d   = '0;
         tx_shift_d = tx_rdata;
`ifdef UART_PARITY_EN
         tx_par_d   = ^tx_rdata ^ OddBit;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_state_q <= StIdle;
         tx_div_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
`ifdef UART_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   // ---------------- RX ----------------
   uart_state_e          rx_state_q, rx_state_d;
   logic [CntW-1:0]      rx_div_q, rx_div_d;
   logic [2:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [EntryW-1:0]    rx_entry_q, rx_entry_d, rx_rdata;
   logic                 rx_push_q, rx_push_d, rx_wrap, rx_full, rx_empty, rx_pop;
   logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
`ifdef UART_PARITY_EN
   logic                 rx_par_bit_q, rx_par_bit_d, rx_par_err;
   assign rx_par_err      = (^rx_shift_q ^ OddBit) != rx_par_bit_q;
   assign rx_parity_err_o = rx_rdata[DATA_BITS+1];
`else
   assign rx_parity_err_o = 1'b0;
`endif

   assign rx_valid_o     = !rx_empty;
   assign rx_pop         = rx_ready_i && !rx_empty;
   assign rx_data_o      = rx_rdata[DATA_BITS-1:0];
   assign rx_frame_err_o = rx_rdata[DATA_BITS];
   assign rx_overrun_o   = rx_push_q && rx_full && !rx_pop;

   uart_sync_fifo #(
      .WIDTH (EntryW),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rx_push_q),
      .wdata_i (rx_entry_q),
      .pop_i   (rx_pop),
      .rdata_o (rx_rdata),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .level_o (rx_level_o)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_entry_d = rx_entry_q;
      rx_push_d  = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bit_d = rx_par_bit_q;
`endif
      rx_wrap    = (rx_div_q == DivLast);
      if (rx_state_q != StIdle) rx_div_d = rx_wrap ? '0 : rx_div_q + CntW'(1);
      unique case (rx_state_q)
         StIdle: begin
            if (rxd_prev_q && !rxd_sync_q) begin
               rx_state_d = StStart;
               rx_div_d   = '0;
            end
         end
         StStart: begin
            // Half-bit check rejects glitches and aligns later samples mid-bit.
            if (rx_div_q == HalfLast) begin
               rx_div_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_sync_q ? StIdle : StData;
            end
         end
         StData: begin
            if (rx_wrap) begin
               rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == DataLast) begin
                  rx_bit_d = '0;
`ifdef UART_PARITY_EN
                  rx_state_d = StParity;
`else
                  rx_state_d = StStop;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         StParity: begin
            if (rx_wrap) begin
               rx_par_bit_d = rxd_sync_q;
               rx_state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (rx_wrap) begin
               rx_push_d  = 1'b1;
`ifdef UART_PARITY_EN
               rx_entry_d = {rx_par_err, !rxd_sync_q, rx_shift_q};
`else
               rx_entry_d = {!rxd_sync_q, rx_shift_q};
`endif
               rx_state_d = StIdle;
            end
         end
         default: rx_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
         rx_state_q <= StIdle;
         rx_div_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_entry_q <= '0;
         rx_push_q  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_bit_q <= 1'b0;
`endif
      end else begin
         rxd_meta_q <= uart_rxd_i;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
         rx_state_q <= rx_state_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_entry_q <= rx_entry_d;
         rx_push_q  <= rx_push_d;
`ifdef UART_PARITY_EN
         rx_par_bit_q <= rx_par_bit_d;
`endif
      end
   end

endmodule
